// File: rtl/axis_write_data.sv
// Packs a narrow word stream into wide AXI W beats through a small beat FIFO.
// Optional define AXIS_WRITE_DATA_STRB_EN: strobes cover only the filled lanes of each beat.
module axis_write_data #(
  parameter int BUF_AWIDTH     = 4,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int WIDTH_RATIO    = 8,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_BEATS    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CONFIG_DWIDTH-1:0]    cfg_length,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [DATA_WIDTH-1:0]       data,
  input  logic                        valid,
  output logic                        ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wlast,
  output logic                        axi_wvalid,
  input  logic                        axi_wready
);

  localparam int DEPTH  = 1 << BUF_AWIDTH;
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int LANE_B = DATA_WIDTH / 8;
  localparam int FIFO_W = AXI_DATA_WIDTH + STRB_W + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [CONFIG_DWIDTH-1:0]  len_q, word_cnt, beat_cnt, lane;
  logic [AXI_DATA_WIDTH-1:0] pack_q, pack_nxt;
  logic [FIFO_W-1:0]         mem [DEPTH];
  logic [BUF_AWIDTH-1:0]     wr_ptr, rd_ptr;
  logic [BUF_AWIDTH:0]       count;
  logic [STRB_W-1:0]         beat_strb;
  logic cfg_acc, word_acc, last_word, beat_done, beat_last;
  logic fifo_wr, fifo_rd, fifo_full, fifo_empty;

`ifdef AXIS_WRITE_DATA_STRB_EN
  function automatic logic [STRB_W-1:0] lane_strb(input logic [CONFIG_DWIDTH-1:0] top_lane);
    logic [STRB_W-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH_RATIO; i++)
      if (CONFIG_DWIDTH'(i) <= top_lane) s[i*LANE_B +: LANE_B] = '1;
    return s;
  endfunction
  assign beat_strb = lane_strb(lane);
`else
  assign beat_strb = '1;
`endif

  assign cfg_acc    = cfg_valid & cfg_ready;
  assign word_acc   = valid & ready;
  assign lane       = word_cnt % CONFIG_DWIDTH'(WIDTH_RATIO);
  assign last_word  = (word_cnt == len_q - CONFIG_DWIDTH'(1));
  assign beat_done  = (lane == CONFIG_DWIDTH'(WIDTH_RATIO - 1)) | last_word;
  assign beat_last  = last_word |
                      ((beat_cnt % CONFIG_DWIDTH'(BURST_BEATS)) == CONFIG_DWIDTH'(BURST_BEATS - 1));
  assign fifo_wr    = word_acc & beat_done;
  assign fifo_full  = (count == (BUF_AWIDTH+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign fifo_rd    = axi_wvalid & axi_wready;

  // FIFO head drives the W channel directly; outputs read as zero while empty
  assign axi_wvalid = ~fifo_empty;
  assign {axi_wdata, axi_wstrb, axi_wlast} = axi_wvalid ? mem[rd_ptr] : '0;

  always_comb begin
    pack_nxt = pack_q;
    for (int i = 0; i < WIDTH_RATIO; i++)
      if (lane == CONFIG_DWIDTH'(i)) pack_nxt[i*DATA_WIDTH +: DATA_WIDTH] = data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_acc && cfg_length != '0) state_nxt = ACTIVE;
      ACTIVE:  if (word_acc && last_word)       state_nxt = DRAIN;
      DRAIN:   if (fifo_empty)                  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == IDLE) & ~rst;
    ready     = (state == ACTIVE) & ~fifo_full & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      word_cnt <= '0;
      beat_cnt <= '0;
      pack_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (cfg_acc) begin
        len_q    <= cfg_length;
        word_cnt <= '0;
        beat_cnt <= '0;
        pack_q   <= '0;
      end
      if (word_acc) begin
        word_cnt <= word_cnt + CONFIG_DWIDTH'(1);
        pack_q   <= beat_done ? '0 : pack_nxt;
      end
      if (fifo_wr) begin
        beat_cnt <= beat_cnt + CONFIG_DWIDTH'(1);
        wr_ptr   <= wr_ptr + BUF_AWIDTH'(1);
      end
      if (fifo_rd) rd_ptr <= rd_ptr + BUF_AWIDTH'(1);
      count <= count + (BUF_AWIDTH+1)'(fifo_wr) - (BUF_AWIDTH+1)'(fifo_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= {pack_nxt, beat_strb, beat_last};
  end

endmodule

// File: tb/tb_axis_write_data.sv
// Directed bench for axis_write_data: a scoreboard of expected W beats filled as words are accepted.
module tb_axis_write_data;

  localparam int DW = 32;
  localparam int AW = 256;
  localparam int SW = AW / 8;

  typedef struct packed {
    logic [AW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   cfg_length = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] data = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic [AW-1:0] axi_wdata;
  logic [SW-1:0] axi_wstrb;
  logic          axi_wlast;
  logic          axi_wvalid;
  logic          axi_wready = 1'b1;

  int    n_checks = 0;
  int    n_pass = 0;
  int    wr_mode = 0;
  int    beats_seen = 0;
  int    lasts_seen = 0;
  int    wvalid_cycles = 0;
  beat_t exp_q[$];

  axis_write_data dut (
    .clk(clk), .rst(rst),
    .cfg_length(cfg_length), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .data(data), .valid(valid), .ready(ready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] exp_strb(input int n);
    logic [SW-1:0] s;
`ifdef AXIS_WRITE_DATA_STRB_EN
    s = '0;
    for (int i = 0; i < n * (DW / 8); i++) s[i] = 1'b1;
`else
    s = '1;
    if (n < 0) s = '0;
`endif
    return s;
  endfunction

  // wready pattern: 0 = always ready, 1 = toggle each cycle, 2 = held low
  initial forever begin
    @(posedge clk);
    #1;
    case (wr_mode)
      1:       axi_wready = ~axi_wready;
      2:       axi_wready = 1'b0;
      default: axi_wready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on each handshake and checks stall stability
  logic          stalled_prev = 1'b0;
  logic [AW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    beat_t e;
    if (axi_wvalid) wvalid_cycles++;
    if (stalled_prev) begin
      check("stall_wvalid", axi_wvalid, 1'b1);
      check("stall_wdata", axi_wdata, prev_data);
      check("stall_wlast", axi_wlast, prev_last);
    end
    if (axi_wvalid && axi_wready) begin
      check("sb_empty_on_beat", exp_q.size() == 0, 1'b0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wdata", axi_wdata, e.wdata);
        check("wstrb", axi_wstrb, e.wstrb);
        check("wlast", axi_wlast, e.wlast);
      end
      beats_seen++;
      if (axi_wlast) lasts_seen++;
    end
    stalled_prev = axi_wvalid && !axi_wready && !rst;
    prev_data    = axi_wdata;
    prev_last    = axi_wlast;
  end

  task automatic start_cfg(input int len);
    bit ok = 0;
    cfg_length = len;
    cfg_valid  = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (cfg_ready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    check("cfg_accept", ok, 1'b1);
  endtask

  task automatic push_word(input logic [DW-1:0] d, output bit ok);
    ok    = 0;
    data  = d;
    valid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (ready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && cfg_ready) begin done = 1; break; end
    end
    @(posedge clk);
    #1;
    check(tag, done, 1'b1);
  endtask

  // Full transfer of words base..base+len-1; hold_at >= 0 inserts the FIFO-full stall
  task automatic xfer(input string tag, input int len, input int base, input int hold_at);
    logic [AW-1:0] acc = '0;
    int lanes = 0;
    int beat_i = 0;
    int b0 = beats_seen;
    int l0 = lasts_seen;
    int s0;
    bit ok;
    start_cfg(len);
    for (int k = 0; k < len; k++) begin
      if (k == hold_at) begin
        data  = DW'(base + k);
        valid = 1'b1;
        repeat (3) @(negedge clk);
        check("full_ready_low", ready, 1'b0);
        check("full_wvalid", axi_wvalid, 1'b1);
        s0 = beats_seen;
        repeat (70) @(negedge clk);
        check("full_no_beats", beats_seen - s0, 0);
        wr_mode = 0;
        @(posedge clk);
        #1;
      end
      push_word(DW'(base + k), ok);
      if (!ok) begin
        check({tag, "_word_timeout"}, ok, 1'b1);
        return;
      end
      acc[lanes*DW +: DW] = DW'(base + k);
      lanes++;
      if (lanes == 8 || k == len - 1) begin
        exp_q.push_back('{wdata: acc, wstrb: exp_strb(lanes),
                          wlast: (k == len - 1) || (beat_i % 16 == 15)});
        acc = '0;
        lanes = 0;
        beat_i++;
      end
    end
    check({tag, "_ready_after_last"}, ready, 1'b0);
    wait_drain({tag, "_drain"});
    check({tag, "_beats"}, beats_seen - b0, (len + 7) / 8);
    check({tag, "_lasts"}, lasts_seen - l0, (((len + 7) / 8) + 15) / 16);
  endtask

  initial begin
    bit ok;
    int w0;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cfg_ready", cfg_ready, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_wvalid", axi_wvalid, 1'b0);
    check("rst_wlast", axi_wlast, 1'b0);
    check("rst_wdata", axi_wdata, '0);
    check("rst_wstrb", axi_wstrb, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_cfg_ready", cfg_ready, 1'b1);
    check("idle_ready", ready, 1'b0);
    @(posedge clk);
    #1;

    // Length 10: full beat then a two-word partial beat
    xfer("len10", 10, 1, -1);

    // Length 256: wlast on beats 16 and 32, then back to idle
    xfer("len256", 256, 1000, -1);
    check("len256_idle_cfg_ready", cfg_ready, 1'b1);
    check("len256_idle_ready", ready, 1'b0);

    // Length 160 with wready held low until the FIFO fills
    wr_mode = 2;
    xfer("len160", 160, 5000, 128);

    // Length 64 with wready toggling
    wr_mode = 1;
    xfer("len64", 64, 20000, -1);
    wr_mode = 0;

    // Reset mid-transfer after 5 of 10 words
    start_cfg(10);
    for (int k = 0; k < 5; k++) push_word(DW'(300 + k), ok);
    check("mid_push_ok", ok, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cfg_ready", cfg_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_wvalid", axi_wvalid, 1'b0);
    check("mid_rst_ready", ready, 1'b0);
    check("mid_rst_cfg_ready_after", cfg_ready, 1'b1);
    check("mid_rst_sb_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    xfer("after_rst_len8", 8, 1, -1);

    // Zero length: accepted, no beats, stays idle
    w0 = wvalid_cycles;
    start_cfg(0);
    repeat (20) begin
      @(negedge clk);
      check("len0_cfg_ready", cfg_ready, 1'b1);
    end
    check("len0_no_wvalid", wvalid_cycles - w0, 0);
    @(posedge clk);
    #1;
    xfer("after_len0_len8", 8, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
